fft_seq: RTL
============

// Module: fft_seq
// PURPOSE
//  Stage/pair sequencer for the in-place radix-2 FFT core. It runs directly upstream of addr_gen.
//  On start it walks every butterfly of every stage and drives the read-side stage/pair that
//  addr_gen turns into even/odd/twiddle read addresses. It also delays those values to produce
//  the write-side stage/pair and write-enable, aligned with the butterfly pipeline output.
//  Between stages it stalls reads until the pipeline has drained, so no read overtakes a
//  pending write.
// PARAMETERS
//  N         16  FFT length; power of 2, >=4. L = $clog2(N) stages.
//  BFLY_LAT  3   cycles from a read issue (o_rd_en) to the matching RAM write; >=1.
// PORTS
//  i_clk       in   1               clock; all state updates on rising edge
//  i_rst       in   1               asynchronous, active-high reset
//  i_start     in   1               start request; sampled only in IDLE
//  o_busy      out  1               high in RUN, DRAIN and DONE
//  o_done      out  1               1-cycle pulse when the transform is complete
//  o_stage     out  $clog2(L)       read-side stage to addr_gen i_stage
//  o_pair      out  $clog2(N)       read-side pair to addr_gen i_pair; range 0..N/2-1
//  o_rd_en     out  1               RAM read enable for the current o_stage/o_pair
//  o_wr_en     out  1               o_rd_en delayed by BFLY_LAT
//  o_wr_stage  out  $clog2(L)       o_stage delayed by BFLY_LAT; feeds write-side addr_gen
//  o_wr_pair   out  $clog2(N)       o_pair delayed by BFLY_LAT
// BEHAVIOUR
//  Reset: state=IDLE. Every output and every delay-line stage resets to 0. Reset is honoured
//   mid-transform; any in-flight reads and writes are discarded (o_wr_en=0 immediately).
//  FSM: IDLE, RUN, DRAIN, DONE.
//   IDLE:  i_start=1 -> RUN. Load o_stage=L-1, o_pair=0, drain counter=0.
//   RUN:   o_rd_en=1 every cycle; o_pair increments by 1 per cycle.
//          At o_pair==N/2-1 -> DRAIN (o_pair stays at N/2-1).
//   DRAIN: o_rd_en=0 for exactly BFLY_LAT cycles (counter 0..BFLY_LAT-1).
//          On the last cycle: if o_stage!=0 -> RUN with o_stage-1 and o_pair=0;
//          else -> DONE.
//   DONE:  o_done=1 for one cycle -> IDLE. o_stage/o_pair hold their last values.
//  Stage order counts down (L-1 first). addr_gen treats stage L-1 as the bit-reversed input
//   stage.
//  i_start is ignored in RUN, DRAIN and DONE; there is no queued restart. A start in the
//   cycle after DONE is accepted.
//  Delay line: BFLY_LAT-deep shift register of {o_rd_en, o_stage, o_pair}. It shifts every
//   cycle in every state, so the final stage's writes complete during its DRAIN.
//  Hazard rule: the last write of stage s occurs in the last DRAIN cycle. The first read of
//   stage s-1 occurs in the following cycle.
//  Timing: start sampled at edge k. First o_rd_en=1 in cycle k+1. Busy length is
//   L*(N/2+BFLY_LAT)+1 cycles including DONE. o_done appears L*(N/2+BFLY_LAT)+1 cycles after
//   the start edge.
//  Counter widths: o_pair is $clog2(N) bits; its MSB is always 0. The drain counter is
//   $clog2(BFLY_LAT+1) bits; it saturates nowhere and is cleared on RUN entry.
//  Pure sequencer: no datapath and no arithmetic beyond the increment/decrement counters.
// TESTING
//  1) N=16, LAT=3: start pulse -> o_rd_en high 8 cycles per stage, 3-cycle gaps, stages
//     3,2,1,0. o_done exactly 45 cycles after the start edge; o_busy high 45 cycles.
//  2) Write alignment: every cycle check o_wr_en/o_wr_stage/o_wr_pair equal o_rd_en/o_stage/
//     o_pair from 3 cycles earlier. Expect 32 write strobes in total, the last one in the
//     cycle before o_done.
//  3) Hazard: cycle of last write (stage 3, pair 7) immediately precedes first read
//     (stage 2, pair 0). No read of stage s-1 occurs before that write.
//  4) Start held high the whole transform -> single run; auto-restart in the cycle after
//     DONE. Start pulsed mid-RUN -> ignored, timing unchanged.
//  5) i_rst asserted during stage 2 RUN, async mid-cycle -> all outputs 0 immediately,
//     state IDLE. Next start gives a full 45-cycle run from stage 3.
//  6) N=4, LAT=1: stages 1,0; 2 reads + 1 gap each; o_done 7 cycles after start.

Source files
------------

// File: rtl/fft_seq.sv
// fft_seq - stage/pair sequencer for the in-place radix-2 FFT core.
// Walks every butterfly per stage, stalls between stages for pipeline drain, delays read side to write side.
module fft_seq #(
  parameter  int N        = 16,
  parameter  int BFLY_LAT = 3,
  localparam int L        = $clog2(N),
  localparam int SW       = $clog2(L),
  localparam int PW       = $clog2(N),
  localparam int CW       = $clog2(BFLY_LAT + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  output logic          o_busy,
  output logic          o_done,
  output logic [SW-1:0] o_stage,
  output logic [PW-1:0] o_pair,
  output logic          o_rd_en,
  output logic          o_wr_en,
  output logic [SW-1:0] o_wr_stage,
  output logic [PW-1:0] o_wr_pair
);

  localparam int DW = 1 + SW + PW;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [PW-1:0]   pair_q, pair_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rd_en_q, rd_en_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [DW-1:0]   dl_q [BFLY_LAT];
  logic [DW-1:0]   dl_d [BFLY_LAT];

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    pair_d  = pair_q;
    cnt_d   = cnt_q;
    rd_en_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = RUN;
          stage_d = SW'(L - 1);
          pair_d  = '0;
          cnt_d   = '0;
          rd_en_d = 1'b1;
        end
      end
      RUN: begin
        if (pair_q == PW'(N / 2 - 1)) begin
          state_d = DRAIN;
        end else begin
          pair_d  = pair_q + PW'(1);
          rd_en_d = 1'b1;
        end
      end
      DRAIN: begin
        // Last drain cycle carries the final write of this stage; next read follows it.
        if (cnt_q == CW'(BFLY_LAT - 1)) begin
          if (stage_q != '0) begin
            state_d = RUN;
            stage_d = stage_q - SW'(1);
            pair_d  = '0;
            cnt_d   = '0;
            rd_en_d = 1'b1;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);

    dl_d[0] = {rd_en_q, stage_q, pair_q};
    for (int i = 1; i < BFLY_LAT; i++) begin
      dl_d[i] = dl_q[i-1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      pair_q  <= '0;
      cnt_q   <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < BFLY_LAT; i++) begin
        dl_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      pair_q  <= pair_d;
      cnt_q   <= cnt_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int i = 0; i < BFLY_LAT; i++) begin
        dl_q[i] <= dl_d[i];
      end
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_stage    = stage_q;
  assign o_pair     = pair_q;
  assign o_rd_en    = rd_en_q;
  assign o_wr_en    = dl_q[BFLY_LAT-1][DW-1];
  assign o_wr_stage = dl_q[BFLY_LAT-1][PW +: SW];
  assign o_wr_pair  = dl_q[BFLY_LAT-1][PW-1:0];

endmodule
